// File: rtl/secuenciador_compuertas.sv
// Sweeps the four {A,B} vectors through a combinational gate unit and returns the captured truth table.
// Optional golden-table check of the captured result: define SECUENCIADOR_CHECK_EN.
module secuenciador_compuertas #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] op,
    output logic       gate_a,
    output logic       gate_b,
    input  logic [6:0] gate_out,
    output logic       busy,
    output logic       result_valid,
    input  logic       result_ready,
    output logic [3:0] tabla,
    output logic       error
`ifdef SECUENCIADOR_CHECK_EN
    ,
    output logic       mismatch
`endif
);

    localparam int unsigned CNT_W  = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned TAB_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic               gate_a_d, gate_b_d;
    logic               busy_d, result_valid_d, error_d;
    logic [TAB_W-1:0]   tabla_d;
`ifdef SECUENCIADOR_CHECK_EN
    logic               mismatch_d;

    // Reference truth table per op, indexed by {A,B}
    function automatic logic [TAB_W-1:0] golden(input logic [OP_W-1:0] sel);
        case (sel)
            3'd0:    golden = 4'b0011;
            3'd1:    golden = 4'b1000;
            3'd2:    golden = 4'b1110;
            3'd3:    golden = 4'b0110;
            3'd4:    golden = 4'b0111;
            3'd5:    golden = 4'b0001;
            3'd6:    golden = 4'b1001;
            default: golden = 4'b0000;
        endcase
    endfunction
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            op_q         <= '0;
            gate_a       <= 1'b0;
            gate_b       <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            tabla        <= '0;
            error        <= 1'b0;
`ifdef SECUENCIADOR_CHECK_EN
            mismatch     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            gate_a       <= gate_a_d;
            gate_b       <= gate_b_d;
            busy         <= busy_d;
            result_valid <= result_valid_d;
            tabla        <= tabla_d;
            error        <= error_d;
`ifdef SECUENCIADOR_CHECK_EN
            mismatch     <= mismatch_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        op_d           = op_q;
        gate_a_d       = gate_a;
        gate_b_d       = gate_b;
        busy_d         = busy;
        result_valid_d = result_valid;
        tabla_d        = tabla;
        error_d        = error;
`ifdef SECUENCIADOR_CHECK_EN
        mismatch_d     = mismatch;
`endif
        case (state_q)
            IDLE: begin
                gate_a_d = 1'b0;
                gate_b_d = 1'b0;
                busy_d   = 1'b0;
                if (start) begin
                    tabla_d = '0;
                    if (op == 3'd7) begin
                        state_d        = DONE;
                        error_d        = 1'b1;
                        result_valid_d = 1'b1;
`ifdef SECUENCIADOR_CHECK_EN
                        mismatch_d     = 1'b0;
`endif
                    end else begin
                        state_d = SWEEP;
                        op_d    = op;
                        idx_d   = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        error_d = 1'b0;
                    end
                end
            end
            SWEEP: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    tabla_d[idx_q] = gate_out[op_q];
                    cnt_d          = '0;
                    idx_d          = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(3)) begin
                        state_d        = DONE;
                        busy_d         = 1'b0;
                        result_valid_d = 1'b1;
                        gate_a_d       = 1'b0;
                        gate_b_d       = 1'b0;
`ifdef SECUENCIADOR_CHECK_EN
                        mismatch_d     = (tabla_d != golden(op_q));
`endif
                    end else begin
                        {gate_a_d, gate_b_d} = idx_d;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_d        = IDLE;
                    result_valid_d = 1'b0;
                    error_d        = 1'b0;
`ifdef SECUENCIADOR_CHECK_EN
                    mismatch_d     = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
